// File: rtl/bit_counter_pkg.sv
// bit_counter_pkg: shared sizing helpers for the bit-counter pipeline chain.
// Contents:
//   cnt_w(width) - number of bits needed to hold a popcount of a width-bit word.
package bit_counter_pkg;

    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/bit_counter_result_buffer_if.sv
// bit_counter_result_buffer_if: signals between the result buffer, the pipeline and the consumer.
// Parameters:
//   CW - count width
//   LW - occupancy width
// Signals:
//   count_i, count_val_i   - result pushed from the last pipeline stage
//   ready_o                - credit to the pipeline head
//   count_o, count_val_o   - head-of-FIFO result offered to the consumer
//   count_ready_i          - consumer accepts count_o
//   level_o                - current occupancy
//   overflow_o             - sticky dropped-push flag
// Modports: master is the pipeline/consumer side, slave is the buffer.
interface bit_counter_result_buffer_if #(
    parameter int CW = 5,
    parameter int LW = 4
);
    logic [CW-1:0] count_i;
    logic          count_val_i;
    logic          ready_o;
    logic [CW-1:0] count_o;
    logic          count_val_o;
    logic          count_ready_i;
    logic [LW-1:0] level_o;
    logic          overflow_o;

    modport master (
        output count_i, count_val_i, count_ready_i,
        input  ready_o, count_o, count_val_o, level_o, overflow_o
    );

    modport slave (
        input  count_i, count_val_i, count_ready_i,
        output ready_o, count_o, count_val_o, level_o, overflow_o
    );
endinterface

// File: rtl/bit_counter_result_buffer.sv
// bit_counter_result_buffer: FIFO for final popcount results with a credit-style ready to the pipeline head.
// Parameters:
//   WIDTH        - data width counted by the pipeline (count width is cnt_w(WIDTH))
//   DEPTH        - FIFO entries, must exceed PIPE_LATENCY
//   PIPE_LATENCY - cycles from pipeline-head acceptance to count_val_i
// Ports:
//   clk_i   - clock, rising edge
//   rst_n_i - asynchronous active-low reset
//   bus     - slave side of bit_counter_result_buffer_if
module bit_counter_result_buffer
    import bit_counter_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int DEPTH        = 8,
    parameter int PIPE_LATENCY = 4
) (
    input logic                         clk_i,
    input logic                         rst_n_i,
    bit_counter_result_buffer_if.slave  bus
);
    localparam int CW = cnt_w(WIDTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
    localparam logic [LW-1:0] READY_MAX = LW'(DEPTH - 1 - PIPE_LATENCY);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

    if (DEPTH <= PIPE_LATENCY) begin : g_depth_check
        $error("DEPTH must be greater than PIPE_LATENCY");
    end

    logic [CW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          push, pop, full, wr_en;

    always_comb begin
        push       = bus.count_val_i;
        pop        = (level_q != '0) && bus.count_ready_i;
        full       = (level_q == FULL_LVL);
        // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
        wr_en      = push && (!full || pop);
        wr_ptr_d   = wr_en ? ((wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d   = pop ? ((rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        level_d    = level_q + LW'(wr_en) - LW'(pop);
        overflow_d = overflow_q || (push && !wr_en);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is intentionally not reset; validity is tracked by level_q alone.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr_q] <= bus.count_i;
    end

    // Credit threshold leaves room for every result that can still be in the pipeline.
    assign bus.ready_o     = (level_q <= READY_MAX);
    assign bus.count_val_o = (level_q != '0);
    // Masked when empty so uninitialised storage never reaches the consumer.
    assign bus.count_o     = (level_q != '0) ? mem[rd_ptr_q] : '0;
    assign bus.level_o     = level_q;
    assign bus.overflow_o  = overflow_q;
endmodule

// File: doc/bit_counter_result_buffer.md
Name: bit_counter_result_buffer

Overview:
Downstream stage of the bit-counter pipeline chain. It captures the final popcount result, count plus valid, from the last pipeline stage into a small FIFO and presents it to a consumer over a valid/ready handshake. The pipeline has no back-pressure, so the block drives a credit-style ready_o to the pipeline head. That signal guarantees every result already in flight has a free slot when it arrives.

Parameters:
WIDTH, 16, data width counted by the pipeline; count width is $clog2(WIDTH)+1
DEPTH, 8, FIFO entries; must be > PIPE_LATENCY (elaboration assertion)
PIPE_LATENCY, 4, cycles from pipeline-head acceptance to count_val_i at this block

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_n_i  input  1  asynchronous reset, active low
count_i  input  $clog2(WIDTH)+1  popcount result from last pipeline stage
count_val_i  input  1  count_i valid (push)
ready_o  output  1  pipeline head may issue a new word this cycle
count_o  output  $clog2(WIDTH)+1  head-of-FIFO result
count_val_o  output  1  count_o valid
count_ready_i  input  1  consumer accepts count_o (pop when count_val_o & count_ready_i)
level_o  output  $clog2(DEPTH+1)  current occupancy
overflow_o  output  1  sticky: push arrived while full and was dropped

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, level_o=0, count_val_o=0, count_o=0, overflow_o=0. Therefore ready_o=1 after reset.
- Storage: DEPTH-entry register array. Contents are not reset.
- push = count_val_i. pop = count_val_o & count_ready_i.
- count_val_o = (level_o != 0). count_o = mem[rd_ptr], read combinationally from registered pointer and array.
- Latency when empty: push at cycle t gives count_val_o=1 and count_o=pushed value at t+1. No same-cycle fall-through.
- Pointers: increment on push/pop and wrap explicitly from DEPTH-1 to 0. No power-of-two requirement.
- Level update:
  - push only: +1
  - pop only: -1
  - both: unchanged, write and read both performed
  - neither: hold
- Full (level_o==DEPTH):
  - push without pop: data dropped, wr_ptr/level unchanged, overflow_o set to 1 and held until reset.
  - push with pop: accepted, no overflow.
- Empty: count_ready_i is ignored because pop cannot occur.
- ready_o = (level_o <= DEPTH-1-PIPE_LATENCY). Combinational from registered level_o only, with no dependence on count_val_i or count_ready_i in the same cycle.
  - This guarantees no overflow when upstream honours ready_o, even if the consumer stalls forever.
- Reset mid-operation: all contents are logically discarded immediately, and outputs go to reset values asynchronously.
- count_o is X-free when count_val_o=0 after reset, because the array is read but the output is 0-masked when empty.

Decomposition:
- Shared package bit_counter_pkg:
  - function cnt_w(WIDTH) returning $clog2(WIDTH)+1.
  - Parameterised count width helper used by both the pipeline stages and this block.
- No sub-module. Storage, pointers and level counter are inline; the block is small enough, around 150 RTL lines.

Test Plan (WIDTH=16, DEPTH=8, PIPE_LATENCY=4; ready_o threshold level_o<=3):
- Reset then single push count_i=5 at cycle t, count_ready_i=0 -> count_val_o=1, count_o=5 at t+1; level_o=1; ready_o=1.
- Push 4 values 1,2,3,4, consumer stalled -> level_o=4, ready_o=0 from the cycle after the 4th push. Further pushes 5,6,7,8 -> level_o=8, overflow_o=0. Drain with count_ready_i=1 -> outputs 1..8 in order.
- Full (level 8), push 9 with count_ready_i=0 -> level stays 8, overflow_o=1 and stays 1 through a subsequent full drain; the popped sequence excludes 9.
- Full, simultaneous push 10 and pop -> level_o stays 8, overflow_o=0, 10 emerges last after draining.
- Continuous push and pop every cycle for 20 cycles with values 0..16 wrapping -> level_o=1 steady, output equals input delayed 1 cycle, pointers wrap cleanly past 7.
- Assert rst_n_i low mid-burst at level 5 -> count_val_o, level_o, overflow_o go to 0 immediately (same cycle, no clock). ready_o=1. The first push after release appears at the output 1 cycle later.
